// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Shadow copy of regfile writebacks, replayed through the core recovery ports on request.
// Optional per-entry even parity: define CV32E40P_RF_RECOVERY_PARITY_EN.
module cv32e40p_rf_recovery_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 64,
    parameter int NUM_WPORTS = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_WPORTS-1:0]            wb_we_i,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wb_wdata_i,
    input  logic                             recover_req_i,
    output logic                             recover_o,
    output logic [NUM_WPORTS-1:0]            regfile_we_o,
    output logic [NUM_WPORTS*ADDR_WIDTH-1:0] regfile_waddr_o,
    output logic [NUM_WPORTS*DATA_WIDTH-1:0] regfile_wdata_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             parity_err_o
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LP_NREGS = CW'(NUM_REGS);
    localparam logic [CW-1:0] LP_NWP   = CW'(NUM_WPORTS);
    localparam logic [CW-1:0] LP_ONE   = CW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_REPLAY, ST_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_req_q;
    logic [CW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_data [NUM_REGS];
    logic [NUM_REGS-1:0]   r_valid;
    logic                  w_edge;
    logic                  w_last;
    logic                  w_replay;
    logic [CW-1:0]         w_ent [NUM_WPORTS];
    logic [ADDR_WIDTH-1:0] w_sel [NUM_WPORTS];
    logic [NUM_WPORTS-1:0] w_ent_ok;

    function automatic logic f_cap_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < LP_NREGS);
    endfunction

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    logic [NUM_REGS-1:0]   r_par;
    logic [NUM_WPORTS-1:0] w_par_bad;
    logic                  r_par_err;

    function automatic logic f_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    always_comb begin
        w_edge      = recover_req_i & ~r_req_q;
        w_last      = (r_idx + LP_NWP) >= LP_NREGS;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_edge) w_state_nxt = ST_REPLAY;
            ST_REPLAY: if (w_last) w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_req_q <= 1'b0;
            r_idx   <= LP_ONE;
        end else begin
            r_state <= w_state_nxt;
            r_req_q <= recover_req_i;
            r_idx   <= (r_state == ST_REPLAY) ? (r_idx + LP_NWP) : LP_ONE;
        end
    end

    // Later ports overwrite earlier ones on a same-address collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) r_data[i] <= '0;
            r_valid <= '0;
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
            r_par   <= '0;
`endif
        end else if (r_state != ST_REPLAY) begin
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (wb_we_i[p] && f_cap_ok(wb_waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    r_data[wb_waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]]  <= wb_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                    r_valid[wb_waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
                    r_par[wb_waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]]   <= f_parity(wb_wdata_i[p*DATA_WIDTH +: DATA_WIDTH]);
`endif
                end
            end
        end
    end

    always_comb begin
        w_replay = (r_state == ST_REPLAY);
        for (int p = 0; p < NUM_WPORTS; p++) begin
            w_ent[p]    = r_idx + CW'(p);
            w_sel[p]    = w_ent[p][ADDR_WIDTH-1:0];
            w_ent_ok[p] = w_replay && (w_ent[p] < LP_NREGS);
        end
    end

    // Replay outputs depend only on registered state, never on the snoop inputs.
    always_comb begin
        regfile_we_o    = '0;
        regfile_waddr_o = '0;
        regfile_wdata_o = '0;
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
        w_par_bad       = '0;
`endif
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (w_ent_ok[p]) begin
                regfile_waddr_o[p*ADDR_WIDTH +: ADDR_WIDTH] = w_sel[p];
                regfile_wdata_o[p*DATA_WIDTH +: DATA_WIDTH] = r_data[w_sel[p]];
                regfile_we_o[p]                             = r_valid[w_sel[p]];
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
                if (r_valid[w_sel[p]] && (f_parity(r_data[w_sel[p]]) != r_par[w_sel[p]])) begin
                    w_par_bad[p]    = 1'b1;
                    regfile_we_o[p] = 1'b0;
                end
`endif
            end
        end
    end

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                             r_par_err <= 1'b0;
        else if (r_state == ST_IDLE && w_edge) r_par_err <= 1'b0;
        else if (w_replay && (|w_par_bad))     r_par_err <= 1'b1;
    end
    assign parity_err_o = r_par_err;
`else
    assign parity_err_o = 1'b0;
`endif

    assign recover_o = w_replay;
    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = (r_state == ST_DONE);

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Directed bench for cv32e40p_rf_recovery_ctrl with NUM_REGS=32, NUM_WPORTS=2.
module tb_cv32e40p_rf_recovery_ctrl;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NW = 2;
    localparam int R  = (NR - 1 + NW - 1) / NW;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NW-1:0]    wb_we_i;
    logic [NW*AW-1:0] wb_waddr_i;
    logic [NW*DW-1:0] wb_wdata_i;
    logic             recover_req_i;
    logic             recover_o;
    logic [NW-1:0]    regfile_we_o;
    logic [NW*AW-1:0] regfile_waddr_o;
    logic [NW*DW-1:0] regfile_wdata_o;
    logic             busy_o;
    logic             done_o;
    logic             parity_err_o;

    int n_vec = 0;
    int n_err = 0;

    logic          exp_v [0:NR];
    logic [DW-1:0] exp_d [0:NR];

    typedef struct {
        logic [1:0]  we;
        logic [5:0]  a0;
        logic [31:0] d0;
        logic [5:0]  a1;
        logic [31:0] d1;
    } wr_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    wr_t  wr_tab [7];
    exp_t ex_tab [7];

    cv32e40p_rf_recovery_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_WPORTS(NW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .recover_req_i(recover_req_i), .recover_o(recover_o),
        .regfile_we_o(regfile_we_o), .regfile_waddr_o(regfile_waddr_o),
        .regfile_wdata_o(regfile_wdata_o), .busy_o(busy_o), .done_o(done_o),
        .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " recover"}, 32'(recover_o), 0);
        chk({tag, " we"}, 32'(regfile_we_o), 0);
        chk({tag, " waddr"}, 32'(regfile_waddr_o), 0);
        chk({tag, " wdata_lo"}, regfile_wdata_o[31:0], 0);
        chk({tag, " wdata_hi"}, regfile_wdata_o[63:32], 0);
        chk({tag, " busy"}, 32'(busy_o), 0);
        chk({tag, " done"}, 32'(done_o), 0);
        chk({tag, " parity_err"}, 32'(parity_err_o), 0);
    endtask

    // Checks a replay whose request edge was just presented; disturb injects writes and a
    // second request edge mid-replay, rst_at asserts reset after checking that batch.
    task automatic run_replay(input string tag, input bit disturb, input int rst_at);
        for (int c = 0; c < R; c++) begin
            @(negedge clk);
            wb_we_i = '0;
            chk($sformatf("%s c%0d recover", tag, c), 32'(recover_o), 1);
            chk($sformatf("%s c%0d busy", tag, c), 32'(busy_o), 1);
            chk($sformatf("%s c%0d done", tag, c), 32'(done_o), 0);
            for (int p = 0; p < NW; p++) begin
                int   ent;
                logic ev;
                ent = 1 + NW * c + p;
                ev  = (ent < NR) ? exp_v[ent] : 1'b0;
                chk($sformatf("%s x%0d we", tag, ent), 32'(regfile_we_o[p]), 32'(ev));
                if (ev) begin
                    chk($sformatf("%s x%0d addr", tag, ent), 32'(regfile_waddr_o[p*AW +: AW]), 32'(ent));
                    chk($sformatf("%s x%0d data", tag, ent), regfile_wdata_o[p*DW +: DW], exp_d[ent]);
                end
            end
            if (disturb && c == 2) begin
                wb_we_i    = 2'b11;
                wb_waddr_i = {6'd5, 6'd3};
                wb_wdata_i = {32'h55, 32'h33};
            end
            if (disturb && c == 4) recover_req_i = 1'b0;
            if (disturb && c == 6) recover_req_i = 1'b1;
            if (c == rst_at) begin
                rst_i         = 1'b1;
                recover_req_i = 1'b0;
                #1;
                chk_all_zero({tag, " mid-replay rst"});
                return;
            end
        end
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done_o), 1);
        chk({tag, " done busy"}, 32'(busy_o), 1);
        chk({tag, " done recover"}, 32'(recover_o), 0);
        chk({tag, " done we"}, 32'(regfile_we_o), 0);
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(busy_o), 0);
        chk({tag, " idle done"}, 32'(done_o), 0);
    endtask

    initial begin
        wr_tab[0] = '{2'b01, 6'd5,  32'hDEADBEEF, 6'd0,  32'h0};
        wr_tab[1] = '{2'b11, 6'd7,  32'h1,        6'd7,  32'h2};
        wr_tab[2] = '{2'b01, 6'd0,  32'hFFFF,     6'd0,  32'h0};
        wr_tab[3] = '{2'b10, 6'd0,  32'h0,        6'd40, 32'h40404040};
        wr_tab[4] = '{2'b11, 6'd12, 32'hA5A5A5A5, 6'd31, 32'h31313131};
        wr_tab[5] = '{2'b11, 6'd1,  32'h11,       6'd2,  32'h22};
        wr_tab[6] = '{2'b10, 6'd13, 32'hBAD,      6'd30, 32'h30};
        ex_tab[0] = '{1,  32'h11};
        ex_tab[1] = '{2,  32'h22};
        ex_tab[2] = '{5,  32'hDEADBEEF};
        ex_tab[3] = '{7,  32'h2};
        ex_tab[4] = '{12, 32'hA5A5A5A5};
        ex_tab[5] = '{30, 32'h30};
        ex_tab[6] = '{31, 32'h31313131};

        rst_i         = 1'b1;
        wb_we_i       = '0;
        wb_waddr_i    = '0;
        wb_wdata_i    = '0;
        recover_req_i = 1'b0;
        for (int i = 0; i <= NR; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_i = 1'b0;

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            wb_we_i    = wr_tab[v].we;
            wb_waddr_i = {wr_tab[v].a1, wr_tab[v].a0};
            wb_wdata_i = {wr_tab[v].d1, wr_tab[v].d0};
        end
        for (int e = 0; e < 7; e++) begin
            exp_v[ex_tab[e].addr] = 1'b1;
            exp_d[ex_tab[e].addr] = ex_tab[e].data;
        end

        // Replay 1: request held high for 40 cycles gives exactly one replay.
        @(negedge clk);
        wb_we_i       = '0;
        recover_req_i = 1'b1;
        run_replay("r1", 1'b0, -1);
        for (int i = 0; i < 40 - (R + 2); i++) begin
            @(negedge clk);
            chk($sformatf("r1 hold c%0d busy", i), 32'(busy_o), 0);
        end

        // Replay 2: x20 written at the request edge, writes and a new edge during replay.
        recover_req_i = 1'b0;
        @(negedge clk);
        recover_req_i = 1'b1;
        wb_we_i       = 2'b01;
        wb_waddr_i    = {6'd0, 6'd20};
        wb_wdata_i    = {32'h0, 32'h2020};
        exp_v[20]     = 1'b1;
        exp_d[20]     = 32'h2020;
        run_replay("r2", 1'b1, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("r2 after c%0d busy", i), 32'(busy_o), 0);
        end

        // Replay 3 confirms replay-time writes were dropped, then reset lands mid-replay.
        recover_req_i = 1'b0;
        @(negedge clk);
        recover_req_i = 1'b1;
        run_replay("r3", 1'b0, 5);
        @(negedge clk);
        rst_i = 1'b0;
        chk("post-rst busy", 32'(busy_o), 0);

        for (int i = 0; i <= NR; i++) exp_v[i] = 1'b0;
        @(negedge clk);
        recover_req_i = 1'b1;
        run_replay("r4", 1'b0, -1);
        recover_req_i = 1'b0;

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
        @(negedge clk);
        wb_we_i    = 2'b01;
        wb_waddr_i = {6'd0, 6'd9};
        wb_wdata_i = {32'h0, 32'h12345678};
        @(negedge clk);
        wb_we_i = '0;
        dut.r_data[9] = dut.r_data[9] ^ 32'h8;
        @(negedge clk);
        recover_req_i = 1'b1;
        run_replay("par", 1'b0, -1);
        chk("par err sticky", 32'(parity_err_o), 1);
        recover_req_i = 1'b0;
        @(negedge clk);
        chk("par err held", 32'(parity_err_o), 1);
        recover_req_i = 1'b1;
        @(negedge clk);
        chk("par err cleared", 32'(parity_err_o), 0);
        recover_req_i = 1'b0;
        repeat (R + 2) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
